// File: rtl/puf_pkg.sv
// puf_pkg: shared state encoding, response width and per-state reset vectors for the RO-PUF sequencer
package puf_pkg;
  localparam int RESP_W = 8;
  typedef enum logic [2:0] {IDLE, R_ALL, R_SCR, R_ARB, SETTLE, RACE, CAPTURE, DONE} state_t;
  localparam logic [2:0] RV_ALL = 3'b111;
  localparam logic [2:0] RV_SCR = 3'b011;
  localparam logic [2:0] RV_ARB = 3'b001;
  localparam logic [2:0] RV_RUN = 3'b000;
  function automatic logic [2:0] rst_vec(state_t s);
    return s == R_SCR ? RV_SCR :
           (s == R_ARB || s == CAPTURE) ? RV_ARB :
           (s == SETTLE || s == RACE) ? RV_RUN : RV_ALL;
  endfunction
endpackage

// File: rtl/puf_phase_timer.sv
// puf_phase_timer: loadable down-counter that flags expiry when it reaches zero
module puf_phase_timer #(
  parameter int W = 4
) (
  input logic clk,
  input logic rst,
  input logic load,
  input logic [W-1:0] val,
  output logic expire
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= rst ? '0 : load ? val : (cnt != '0) ? cnt - W'(1) : cnt;
  assign expire = cnt == '0;
endmodule

// File: rtl/puf_race_sequencer.sv
// puf_race_sequencer: RO-PUF response controller sequencing resets, races and winner-bit capture
module puf_race_sequencer
  import puf_pkg::*;
#(
  parameter int N_BITS = RESP_W,
  parameter int RST_CYCLES = 2,
  parameter int SETTLE_CYC = 4,
  parameter int TIMEOUT_CYC = 1024,
  localparam int IDX_W = N_BITS > 1 ? $clog2(N_BITS) : 1
) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic [7:0] challenge,
  input logic arb_done,
  input logic arb_winner,
  output logic counter_rst,
  output logic scrambler_rst,
  output logic arbiter_rst,
  output logic race_en,
  output logic [7:0] race_chal,
  output logic [IDX_W-1:0] race_idx,
  output logic busy,
  output logic [N_BITS-1:0] response,
  output logic resp_valid,
  output logic resp_err
);
  localparam int PMAX = RST_CYCLES > SETTLE_CYC ? RST_CYCLES : SETTLE_CYC;
  localparam int PW = $clog2(PMAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_t state, ns;
  logic chg, last, p_done, t_done;
  logic [PW-1:0] p_val;
  assign chg = ns != state;
  assign last = race_idx == IDX_W'(N_BITS - 1);
  assign p_val = (ns == SETTLE) ? PW'(SETTLE_CYC - 1) : PW'(RST_CYCLES - 1);
  puf_phase_timer #(.W(PW)) u_phase (
    .clk(clk),
    .rst(rst),
    .load(chg),
    .val(p_val),
    .expire(p_done)
  );
  puf_phase_timer #(.W(TW)) u_timeout (
    .clk(clk),
    .rst(rst),
    .load(chg),
    .val(TW'(TIMEOUT_CYC - 1)),
    .expire(t_done)
  );
  always_comb begin
    ns = state;
    case (state)
      IDLE: ns = start ? R_ALL : IDLE;
      R_ALL: ns = p_done ? R_SCR : R_ALL;
      R_SCR: ns = p_done ? R_ARB : R_SCR;
      R_ARB: ns = p_done ? SETTLE : R_ARB;
      SETTLE: ns = p_done ? RACE : SETTLE;
      RACE: ns = arb_done ? CAPTURE : t_done ? DONE : RACE;
      CAPTURE: ns = last ? DONE : R_ALL;
      default: ns = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {counter_rst, scrambler_rst, arbiter_rst} <= RV_ALL;
      race_en <= 1'b0;
      race_chal <= '0;
      race_idx <= '0;
      busy <= 1'b0;
      response <= '0;
      resp_valid <= 1'b0;
      resp_err <= 1'b0;
    end else begin
      state <= ns;
      {counter_rst, scrambler_rst, arbiter_rst} <= rst_vec(ns);
      race_en <= ns == RACE;
      busy <= ns != IDLE;
      resp_valid <= ns == DONE;
      if (state == IDLE && start) begin
        race_chal <= challenge;
        race_idx <= '0;
        response <= '0;
        resp_err <= 1'b0;
      end
      if (state == RACE && (arb_done || t_done)) begin
        response <= {response[N_BITS-2:0], arb_done & arb_winner};
        resp_err <= ~arb_done;
      end
      if (state == CAPTURE && !last)
        race_idx <= race_idx + IDX_W'(1);
    end
  end
endmodule

// File: tb/tb_puf_race_sequencer.sv
// tb_puf_race_sequencer: schedule-model checks of reset ordering, races, timeouts, ignored starts and mid-run reset
module tb_puf_race_sequencer;
  localparam int N = 8;
  localparam int R = 2;
  localparam int S = 4;
  localparam int T = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic arb_done = 1'b0;
  logic arb_winner = 1'b0;
  logic [7:0] challenge = '0;
  logic counter_rst, scrambler_rst, arbiter_rst, race_en, busy, resp_valid, resp_err;
  logic [7:0] race_chal, response;
  logic [2:0] race_idx;
  typedef struct packed {
    logic [2:0] rv;
    logic en;
    logic [7:0] chal;
    logic [2:0] idx;
    logic busy;
    logic [7:0] resp;
    logic valid;
    logic err;
  } out_t;
  typedef struct {
    logic start;
    logic [7:0] chal;
    logic ad;
    logic aw;
    out_t exp;
  } cyc_t;
  typedef struct {
    logic [7:0] c;
    logic [7:0] w;
    logic [0:7][4:0] d;
    logic [7:0] er;
    logic ee;
  } vec_t;
  localparam out_t RST_OUT = {3'b111, 23'd0};
  cyc_t q[$];
  logic [7:0] m_chal = '0;
  logic [7:0] m_resp = '0;
  logic [2:0] m_idx = '0;
  logic m_err = 1'b0;
  int checks = 0;
  int errors = 0;
  int n_tx = 0;
  int n_valid = 0;
  out_t act;
  assign act = {counter_rst, scrambler_rst, arbiter_rst, race_en, race_chal, race_idx, busy, response, resp_valid, resp_err};
  always #5 clk = ~clk;
  puf_race_sequencer #(
    .N_BITS(N),
    .RST_CYCLES(R),
    .SETTLE_CYC(S),
    .TIMEOUT_CYC(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .challenge(challenge),
    .arb_done(arb_done),
    .arb_winner(arb_winner),
    .counter_rst(counter_rst),
    .scrambler_rst(scrambler_rst),
    .arbiter_rst(arbiter_rst),
    .race_en(race_en),
    .race_chal(race_chal),
    .race_idx(race_idx),
    .busy(busy),
    .response(response),
    .resp_valid(resp_valid),
    .resp_err(resp_err)
  );
  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, a, e);
    end
  endtask
  function automatic logic noise(input int k);
    return $urandom_range(k - 1) == 0;
  endfunction
  task automatic add(input logic [2:0] rv, input logic en, input logic b, input logic v,
                     input logic ad, input logic aw, input logic st);
    cyc_t e;
    e.start = st;
    e.chal = 8'($urandom);
    e.ad = ad;
    e.aw = aw;
    e.exp = {rv, en, m_chal, m_idx, b, m_resp, v, m_err};
    q.push_back(e);
  endtask
  task automatic build(input logic [7:0] c, input logic [7:0] w, input logic [0:7][4:0] d);
    add(3'b111, 1'b0, 1'b0, 1'b0, noise(3), noise(2), 1'b1);
    q[q.size() - 1].chal = c;
    m_chal = c;
    m_resp = '0;
    m_idx = '0;
    m_err = 1'b0;
    for (int i = 0; i < N; i++) begin
      logic ok;
      int len;
      m_idx = 3'(i);
      for (int k = 0; k < R; k++) add(3'b111, 1'b0, 1'b1, 1'b0, noise(3), noise(2), noise(8));
      for (int k = 0; k < R; k++) add(3'b011, 1'b0, 1'b1, 1'b0, noise(3), noise(2), noise(8));
      for (int k = 0; k < R; k++) add(3'b001, 1'b0, 1'b1, 1'b0, noise(3), noise(2), noise(8));
      for (int k = 0; k < S; k++) add(3'b000, 1'b0, 1'b1, 1'b0, noise(3), noise(2), noise(8));
      ok = d[i] != 0 && int'(d[i]) <= T;
      len = ok ? int'(d[i]) : T;
      for (int k = 1; k <= len; k++)
        add(3'b000, 1'b1, 1'b1, 1'b0, ok && k == len, (ok && k == len) ? w[7 - i] : noise(2), noise(8));
      m_resp = {m_resp[6:0], ok & w[7 - i]};
      if (!ok) begin
        m_err = 1'b1;
        break;
      end
      add(3'b001, 1'b0, 1'b1, 1'b0, noise(3), noise(2), noise(8));
    end
    add(3'b111, 1'b0, 1'b1, 1'b1, noise(3), noise(2), noise(8));
    for (int k = 0; k < 2; k++) add(3'b111, 1'b0, 1'b0, 1'b0, noise(3), noise(2), 1'b0);
  endtask
  task automatic run(input int abort_idx);
    while (q.size() > 0) begin
      cyc_t e;
      e = q.pop_front();
      start = e.start;
      challenge = e.chal;
      arb_done = e.ad;
      arb_winner = e.aw;
      if (e.exp.en && int'(e.exp.idx) == abort_idx) begin
        rst = 1'b1;
        @(negedge clk);
        check("pre_rst", act, e.exp);
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        arb_done = 1'b0;
        @(negedge clk);
        check("mid_rst", act, RST_OUT);
        if (resp_valid) n_valid++;
        q.delete();
        m_chal = '0;
        m_resp = '0;
        m_idx = '0;
        m_err = 1'b0;
        @(posedge clk);
        #1;
        return;
      end
      @(negedge clk);
      check("cycle", act, e.exp);
      if (e.exp.valid) n_tx++;
      if (resp_valid) n_valid++;
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    vec_t tbl[5];
    tbl[0] = '{8'hA5, 8'b10110010, {8{5'd10}}, 8'hB2, 1'b0};
    tbl[1] = '{8'h3C, 8'b10100000, {5'd10, 5'd10, 5'd10, 5'd0, {4{5'd10}}}, 8'h0A, 1'b1};
    tbl[2] = '{8'h5A, 8'hC3, {5'd1, 5'd3, 5'd16, 5'd5, 5'd2, 5'd7, 5'd16, 5'd1}, 8'hC3, 1'b0};
    tbl[3] = '{8'hFF, 8'hFF, {8{5'd0}}, 8'h00, 1'b1};
    tbl[4] = '{8'h01, 8'hFF, {8{5'd1}}, 8'hFF, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset", act, RST_OUT);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int t = 0; t < 5; t++) begin
      build(tbl[t].c, tbl[t].w, tbl[t].d);
      run(-1);
      check("tbl_resp", response, tbl[t].er);
      check("tbl_err", resp_err, tbl[t].ee);
      check("tbl_idle", busy, 1'b0);
    end
    for (int r = 0; r < 6; r++) begin
      logic [0:7][4:0] d;
      for (int i = 0; i < N; i++) d[i] = noise(10) ? 5'd0 : 5'($urandom_range(1, T));
      build(8'($urandom), 8'($urandom), d);
      run(-1);
    end
    build(8'h96, 8'($urandom), {8{5'd10}});
    run(5);
    build(tbl[0].c, tbl[0].w, tbl[0].d);
    run(-1);
    check("post_rst_resp", response, 8'hB2);
    check("post_rst_err", resp_err, 1'b0);
    check("valid_count", n_valid, n_tx);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
